// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_unit_pkg -- shared core definitions for the M-extension unit.
//   muldiv_op_t  : 3-bit operation code, shared by decode and execute.
//   MULDIV_ITER  : number of radix-2 iterations per operation.
//   CNT_W        : width of the iteration counter.
//   abs_val()    : magnitude of a 32-bit value under a given signedness.
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = 5;

    // 0x80000000 maps onto itself, which is also its correct unsigned magnitude.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative 32-bit multiply/divide unit, fixed latency.
//
// Ports
//   clk        in   core clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request an operation (accepted in IDLE or DONE only)
//   op         in   muldiv_op_t operation select
//   operand_a  in   rs1: multiplicand / dividend
//   operand_b  in   rs2: multiplier / divisor
//   flush      in   synchronous abort of the operation in flight
//   busy       out  high in CALC and FIX (execute-stage stall)
//   done       out  one-cycle pulse, result valid in that cycle
//   result     out  registered result, held until the next done
//
// Handshake: start is a request with no back-pressure signal; it is taken
// only on an edge where the unit is in IDLE or DONE and flush is low.
// Exactly 34 edges after acceptance (33 to reach DONE) done pulses for one
// cycle. Ignored requests are dropped, not queued.
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state, state_nxt;
    muldiv_op_t       op_in, op_q;
    logic [31:0]      hi, lo, opnd;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, b_zero_q;

    logic             accept, last_iter, is_div;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [31:0]      a_mag, b_mag;
    logic [33:0]      add_base, add_opnd, add_sum;
    logic [63:0]      prod_s;
    logic [31:0]      quo_s, rem_s, fix_val;

    assign op_in     = muldiv_op_t'(op);
    assign accept    = start && !flush && (state == S_IDLE || state == S_DONE);
    assign last_iter = (cnt == CNT_W'(MULDIV_ITER - 1));
    assign is_div    = op_q[2];

    // Operand signedness of the incoming request.
    assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
    assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign a_neg    = a_signed && operand_a[31];
    assign b_neg    = b_signed && operand_b[31];
    assign a_mag    = abs_val(operand_a, a_signed);
    assign b_mag    = abs_val(operand_b, b_signed);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_CALC : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // One shared 34-bit adder per iteration.
    //   multiply: {0,hi} + (lo[0] ? multiplicand : 0), then {sum,lo} >> 1
    //   divide  : {hi,lo[31]} - divisor (two's complement add), restore on borrow
    always_comb begin
        if (is_div) begin
            add_base = {1'b0, hi, lo[31]};
            add_opnd = ~{2'b00, opnd};
        end else begin
            add_base = {2'b00, hi};
            add_opnd = lo[0] ? {2'b00, opnd} : 34'd0;
        end
        add_sum = add_base + add_opnd + {33'd0, is_div};
    end

    // Sign correction and special cases. Divide-by-zero already leaves the
    // dividend magnitude in hi, so only the quotient needs overriding; the
    // 0x80000000 / -1 overflow falls out of the magnitude arithmetic.
    always_comb begin
        prod_s  = neg_q ? (64'd0 - {hi, lo}) : {hi, lo};
        quo_s   = neg_q ? (32'd0 - lo) : lo;
        rem_s   = neg_q ? (32'd0 - hi) : hi;
        fix_val = 32'd0;
        case (op_q)
            OP_MUL:                      fix_val = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[63:32];
            OP_DIV, OP_DIVU:             fix_val = b_zero_q ? 32'hFFFF_FFFF : quo_s;
            OP_REM, OP_REMU:             fix_val = rem_s;
            default:                     fix_val = 32'd0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            hi       <= 32'd0;
            lo       <= 32'd0;
            opnd     <= 32'd0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
            result   <= 32'd0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                cnt      <= '0;
                hi       <= 32'd0;
                b_zero_q <= (operand_b == 32'd0);
                if (op_in[2]) begin
                    lo    <= a_mag;
                    opnd  <= b_mag;
                    // op[1] separates REM/REMU from DIV/DIVU
                    neg_q <= op_in[1] ? a_neg : (a_neg ^ b_neg);
                end else begin
                    lo    <= b_mag;
                    opnd  <= a_mag;
                    neg_q <= a_neg ^ b_neg;
                end
            end else if (state == S_CALC) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    if (!add_sum[33]) begin
                        hi <= add_sum[31:0];
                        lo <= {lo[30:0], 1'b1};
                    end else begin
                        hi <= add_base[31:0];
                        lo <= {lo[30:0], 1'b0};
                    end
                end else begin
                    hi <= add_sum[32:1];
                    lo <= {add_sum[0], lo[31:1]};
                end
            end
            if (state == S_FIX && !flush) result <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (a),
        .operand_b (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'd0, x};
        zy = {32'd0, y};
        model = 32'd0;
        case (o)
            OP_MUL:    begin p = zx * zy; model = p[31:0];  end
            OP_MULH:   begin p = sx * sy; model = p[63:32]; end
            OP_MULHSU: begin p = sx * zy; model = p[63:32]; end
            OP_MULHU:  begin p = zx * zy; model = p[63:32]; end
            OP_DIV: begin
                if (y == 32'd0)                                  model = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else                                             model = $signed(x) / $signed(y);
            end
            OP_DIVU:   model = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            OP_REM: begin
                if (y == 32'd0)                                  model = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = 32'd0;
                else                                             model = $signed(x) % $signed(y);
            end
            OP_REMU:   model = (y == 32'd0) ? x : x % y;
            default:   model = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: present a request and record its expected result.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(model(o, x, y));
    endtask

    // Let the pending request be accepted, scramble the inputs, and wait for
    // done. poke_at != 0 raises start for one cycle while the unit is busy.
    // Returns at the negedge of the done cycle.
    task automatic finish_op(input string tag, input int poke_at);
        int          cyc;
        bit          seen;
        logic [31:0] e;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(7, 0));
        a     = $urandom;
        b     = $urandom;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (poke_at != 0 && cyc == poke_at)     start = 1'b1;
            if (poke_at != 0 && cyc == poke_at + 1) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, 32'(cyc), 32'd34);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " result"}, result, e);
        last_res = e;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        finish_op(tag, 0);
        @(negedge clk);
        check({tag, " idle done"}, {31'd0, done}, 32'd0);
        check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        check({tag, " held"}, result, last_res);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;

        // reset
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed products
        run("mul 7*-3",   OP_MUL,   32'd7,          32'hFFFF_FFFD);
        check("mul 7*-3 const", last_res, 32'hFFFF_FFEB);
        run("mulhu max",  OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        check("mulhu const", last_res, 32'hFFFF_FFFE);
        run("mulh min",   OP_MULH,  32'h8000_0000,  32'h8000_0000);
        check("mulh const", last_res, 32'h4000_0000);

        // directed divides and special cases
        run("div -7/2",   OP_DIV,   32'hFFFF_FFF9,  32'd2);
        check("div const", last_res, 32'hFFFF_FFFD);
        run("rem -7/2",   OP_REM,   32'hFFFF_FFF9,  32'd2);
        check("rem const", last_res, 32'hFFFF_FFFF);
        run("divu 100/7", OP_DIVU,  32'd100,        32'd7);
        run("remu 100/7", OP_REMU,  32'd100,        32'd7);
        run("divu 5/0",   OP_DIVU,  32'd5,          32'd0);
        run("remu 5/0",   OP_REMU,  32'd5,          32'd0);
        run("div -5/0",   OP_DIV,   32'hFFFF_FFFB,  32'd0);
        run("rem -5/0",   OP_REM,   32'hFFFF_FFFB,  32'd0);
        run("div ovf",    OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
        run("rem ovf",    OP_REM,   32'h8000_0000,  32'hFFFF_FFFF);

        // flush at the 10th CALC cycle
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result", result, last_res);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush no done", 32'(dones), 32'd0);
        check("flush result kept", result, last_res);
        run("divu 9/3", OP_DIVU, 32'd9, 32'd3);

        // flush and start together: start ignored
        start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", {31'd0, busy}, 32'd0);

        // back-to-back, with an ignored start while busy
        issue(OP_DIV, 32'hFFFF_FF00, 32'd16);
        finish_op("b2b first", 10);
        issue(OP_MUL, 32'd2, 32'd5);
        finish_op("b2b second", 0);
        check("b2b const", last_res, 32'd10);
        @(negedge clk);
        check("b2b idle busy", {31'd0, busy}, 32'd0);

        // reset at the 15th CALC cycle
        start = 1'b1; op = OP_MULH; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst result", result, 32'd0);
        last_res = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("mulhsu -1*2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
        check("mulhsu const", last_res, 32'hFFFF_FFFF);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run("random", 3'($urandom_range(7, 0)), pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
